// File: rtl/instruction_queue.sv
// ============================================================================
// Module      : instruction_queue
// Description : DEPTH-entry FIFO of instruction words between fetch and
//               control/decode, presenting the decoded head entry.
//               Optional macro IQ_PEEK_EN adds a decoded view of the entry
//               behind the head for two-word instruction lookahead.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_queue #(
    parameter int WORD_W = 16,
    parameter int OPC_W  = 7,
    parameter int OPR_W  = 3,
    parameter int DEPTH  = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic [WORD_W-1:0]        in,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     advance,
    output logic                     out_valid,
    output logic [WORD_W-1:0]        outWord,
    output logic [OPC_W-1:0]         outOpcode,
    output logic [OPR_W-1:0]         outOp0,
    output logic [OPR_W-1:0]         outOp1,
    output logic [OPR_W-1:0]         outOp2,
    output logic [$clog2(DEPTH):0]   count
`ifdef IQ_PEEK_EN
    ,
    output logic                     peek_valid,
    output logic [WORD_W-1:0]        peekWord,
    output logic [OPC_W-1:0]         peekOpcode,
    output logic [OPR_W-1:0]         peekOp0,
    output logic [OPR_W-1:0]         peekOp1,
    output logic [OPR_W-1:0]         peekOp2
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_FULL    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] C_PTR_ONE = PTR_W'(1);

    if (OPC_W + 3 * OPR_W != WORD_W) begin : g_badFieldWidths
        $error("instruction_queue: OPC_W + 3*OPR_W must equal WORD_W");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_badDepth
        $error("instruction_queue: DEPTH must be a power of two >= 2");
    end

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wrPtr;
    logic [PTR_W-1:0]  r_rdPtr;
    logic [CNT_W-1:0]  r_count;
    logic              w_push;
    logic              w_pop;

    // Ready depends only on registered state, so a full queue refuses a
    // word even in a cycle where the head is being consumed.
    assign in_ready  = reset_n && (r_count != C_FULL);
    assign out_valid = reset_n && (r_count != '0);
    assign w_push    = in_valid && in_ready && !flush;
    assign w_pop     = advance && out_valid && !flush;
    assign count     = r_count;

    assign outWord   = out_valid ? r_mem[r_rdPtr] : '0;
    assign outOpcode = outWord[WORD_W-1 -: OPC_W];
    assign outOp0    = outWord[3*OPR_W-1 -: OPR_W];
    assign outOp1    = outWord[2*OPR_W-1 -: OPR_W];
    assign outOp2    = outWord[OPR_W-1:0];

    always_ff @(posedge clock) begin
        if (!reset_n || flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + C_PTR_ONE;
            if (w_pop)  r_rdPtr <= r_rdPtr + C_PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + C_CNT_ONE;
                2'b01:   r_count <= r_count - C_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is intentionally left uninitialised; outputs are masked by valid.
    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wrPtr] <= in;
    end

`ifdef IQ_PEEK_EN
    logic [PTR_W-1:0] w_peekPtr;

    assign w_peekPtr  = r_rdPtr + C_PTR_ONE;
    assign peek_valid = reset_n && (r_count >= CNT_W'(2));
    assign peekWord   = peek_valid ? r_mem[w_peekPtr] : '0;
    assign peekOpcode = peekWord[WORD_W-1 -: OPC_W];
    assign peekOp0    = peekWord[3*OPR_W-1 -: OPR_W];
    assign peekOp1    = peekWord[2*OPR_W-1 -: OPR_W];
    assign peekOp2    = peekWord[OPR_W-1:0];
`endif

endmodule

`default_nettype wire

// File: tb/tb_instruction_queue.sv
// ============================================================================
// Module      : tb_instruction_queue
// Description : Directed, scoreboard-based bench for instruction_queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_queue;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        flush;
    logic [15:0] inWord;
    logic        in_valid;
    logic        in_ready;
    logic        advance;
    logic        out_valid;
    logic [15:0] outWord;
    logic [6:0]  outOpcode;
    logic [2:0]  outOp0;
    logic [2:0]  outOp1;
    logic [2:0]  outOp2;
    logic [2:0]  count;
`ifdef IQ_PEEK_EN
    logic        peek_valid;
    logic [15:0] peekWord;
    logic [6:0]  peekOpcode;
    logic [2:0]  peekOp0;
    logic [2:0]  peekOp1;
    logic [2:0]  peekOp2;
`endif

    int          vectors     = 0;
    int          miscompares = 0;
    logic [15:0] sb[$];

    always #5 clock = ~clock;

    instruction_queue #(
        .WORD_W(16), .OPC_W(7), .OPR_W(3), .DEPTH(4)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (flush),
        .in        (inWord),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .advance   (advance),
        .out_valid (out_valid),
        .outWord   (outWord),
        .outOpcode (outOpcode),
        .outOp0    (outOp0),
        .outOp1    (outOp1),
        .outOp2    (outOp2),
        .count     (count)
`ifdef IQ_PEEK_EN
        ,
        .peek_valid(peek_valid),
        .peekWord  (peekWord),
        .peekOpcode(peekOpcode),
        .peekOp0   (peekOp0),
        .peekOp1   (peekOp1),
        .peekOp2   (peekOp2)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, check outputs against the scoreboard, then clock.
    task automatic cycle(input logic rstn, input logic iv, input logic [15:0] w,
                         input logic adv, input logic fl);
        logic        expReady;
        logic        expValid;
        logic [15:0] expHead;
        reset_n  = rstn;
        in_valid = iv;
        inWord   = w;
        advance  = adv;
        flush    = fl;
        #1;
        expReady = rstn && (sb.size() < 4);
        expValid = rstn && (sb.size() != 0);
        expHead  = expValid ? sb[0] : 16'h0;
        chk("in_ready",  32'(in_ready),  32'(expReady));
        chk("out_valid", 32'(out_valid), 32'(expValid));
        chk("outWord",   32'(outWord),   32'(expHead));
        chk("outOpcode", 32'(outOpcode), 32'(expHead[15:9]));
        chk("outOp0",    32'(outOp0),    32'(expHead[8:6]));
        chk("outOp1",    32'(outOp1),    32'(expHead[5:3]));
        chk("outOp2",    32'(outOp2),    32'(expHead[2:0]));
        if (rstn) chk("count", 32'(count), 32'(sb.size()));
`ifdef IQ_PEEK_EN
        begin
            logic        expPv;
            logic [15:0] expPeek;
            expPv   = rstn && (sb.size() >= 2);
            expPeek = expPv ? sb[1] : 16'h0;
            chk("peek_valid", 32'(peek_valid), 32'(expPv));
            chk("peekWord",   32'(peekWord),   32'(expPeek));
            chk("peekOpcode", 32'(peekOpcode), 32'(expPeek[15:9]));
            chk("peekOp2",    32'(peekOp2),    32'(expPeek[2:0]));
        end
`endif
        if (!rstn || fl) begin
            sb.delete();
        end else begin
            if (adv && sb.size() != 0) void'(sb.pop_front());
            if (iv && expReady) sb.push_back(w);
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        // 1: reset held two cycles, then released
        cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);

        // 2: single push into empty queue, explicit decode
        cycle(1'b1, 1'b1, 16'hA5C3, 1'b0, 1'b0);
        chk("t2_valid",  32'(out_valid), 32'd1);
        chk("t2_opcode", 32'(outOpcode), 32'h52);
        chk("t2_op0",    32'(outOp0),    32'b111);
        chk("t2_op1",    32'(outOp1),    32'b000);
        chk("t2_op2",    32'(outOp2),    32'b011);
        chk("t2_count",  32'(count),     32'd1);
        cycle(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);  // advance on empty is ignored

        // 3: fill, hold a fifth word against a full queue, then drain
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 16'(16'h2000 + i * 16'h0111), 1'b0, 1'b0);
        chk("t3_full_count", 32'(count),    32'd4);
        chk("t3_full_ready", 32'(in_ready), 32'd0);
        cycle(1'b1, 1'b1, 16'hBEEF, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 16'hBEEF, 1'b1, 1'b0);
        chk("t3_ready_after_pop", 32'(in_ready), 32'd1);
        cycle(1'b1, 1'b1, 16'hBEEF, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);

        // 4: stream through the pointer wrap while advancing
        for (int i = 0; i < 10; i++)
            cycle(1'b1, 1'b1, 16'(16'h1000 + i), (sb.size() != 0), 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);

        // 5: flush with simultaneous push and advance
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 16'(16'h3000 + i), 1'b0, 1'b0);
        chk("t5_count3", 32'(count), 32'd3);
        cycle(1'b1, 1'b1, 16'hCAFE, 1'b1, 1'b1);
        chk("t5_count",   32'(count),     32'd0);
        chk("t5_valid",   32'(out_valid), 32'd0);
        chk("t5_outWord", 32'(outWord),   32'd0);
        chk("t5_ready",   32'(in_ready),  32'd1);
        cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);

`ifdef IQ_PEEK_EN
        // 6: lookahead on the entry behind the head
        cycle(1'b1, 1'b1, 16'h1234, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 16'h5678, 1'b0, 1'b0);
        chk("t6_outWord",  32'(outWord),    32'h1234);
        chk("t6_peekWord", 32'(peekWord),   32'h5678);
        chk("t6_peekV",    32'(peek_valid), 32'd1);
        cycle(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
        chk("t6_peekV0",   32'(peek_valid), 32'd0);
        chk("t6_peekW0",   32'(peekWord),   32'd0);
        cycle(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
`endif

        // reset mid-traffic clears the queue
        cycle(1'b1, 1'b1, 16'h7777, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 16'h8888, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
